// File: rtl/curve_contrast_lut_stream.sv
// Streaming contrast-curve mapper.
// Every channel of the pixel bus is remapped through a runtime-programmable
// curve table. The table is double-buffered (active / shadow bank): the
// config bus writes the shadow bank, and a requested swap is applied only on
// the rising edge of the frame sync, so a frame never mixes two curves.
// After reset an init FSM loads the identity curve into both banks; the
// datapath is forced to bypass until that fill has finished.
// Latency is a fixed 2 cycles with no backpressure.

module curve_contrast_lut_stream #(
  parameter int DATA_W = 8,
  parameter int CH_NUM = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // input video stream
  input  logic                       per_frame_vsync,
  input  logic                       per_frame_href,
  input  logic                       per_frame_clken,
  input  logic [CH_NUM*DATA_W-1:0]   per_img_data,
  // output video stream
  output logic                       post_frame_vsync,
  output logic                       post_frame_href,
  output logic                       post_frame_clken,
  output logic [CH_NUM*DATA_W-1:0]   post_img_data,
  // configuration bus
  input  logic                       cfg_wr_en,
  input  logic [DATA_W-1:0]          cfg_wr_addr,
  input  logic [DATA_W-1:0]          cfg_wr_data,
  input  logic                       cfg_swap_req,
  input  logic                       cfg_bypass,
  // status
  output logic                       init_done,
  output logic                       swap_pending,
  output logic                       active_bank
);

  localparam int DEPTH = 1 << DATA_W;
  localparam int PIX_W = CH_NUM * DATA_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [DATA_W-1:0] init_addr_reg;

  // FSM decoded controls
  logic              init_wr;
  logic              run_en;

  // shared table write port (same address/data for every channel copy)
  logic [DATA_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              we_bank0;
  logic              we_bank1;

  // stage 1 registers
  logic              vsync_s1_reg;
  logic              href_s1_reg;
  logic              clken_s1_reg;
  logic [PIX_W-1:0]  pix_s1_reg;
  logic              bypass_s1_reg;
  logic              bank_s1_reg;

  // frame start detect; the stage-1 vsync doubles as the delayed sync
  logic              vs_rise;

  assign vs_rise = per_frame_vsync & ~vsync_s1_reg;

  // ---------------------------------------------------------------------
  // Init / run FSM
  // ---------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: leave INIT after the last table entry has been written
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT: begin
        if (init_addr_reg == {DATA_W{1'b1}}) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // Outputs decoded from the state
  always_comb begin
    init_wr   = 1'b0;
    run_en    = 1'b0;
    init_done = 1'b0;
    case (state_reg)
      ST_INIT: begin
        init_wr = 1'b1;
      end
      ST_RUN: begin
        run_en    = 1'b1;
        init_done = 1'b1;
      end
      default: begin
        init_wr = 1'b0;
      end
    endcase
  end

  // Identity-fill address counter, walks every table entry once after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_addr_reg <= '0;
    end else if (init_wr) begin
      init_addr_reg <= init_addr_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Bank swap control
  // ---------------------------------------------------------------------

  // Swap is applied on a vsync rise; a request in that same cycle counts too
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_bank  <= 1'b0;
      swap_pending <= 1'b0;
    end else if (run_en) begin
      if (vs_rise && (swap_pending || cfg_swap_req)) begin
        active_bank  <= ~active_bank;
        swap_pending <= 1'b0;
      end else if (cfg_swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Table write port
  // ---------------------------------------------------------------------

  // INIT writes both banks; RUN writes only the shadow bank, chosen from the
  // pre-edge active_bank so a write in a swap cycle lands in the new bank.
  always_comb begin
    wr_addr  = cfg_wr_addr;
    wr_data  = cfg_wr_data;
    we_bank0 = 1'b0;
    we_bank1 = 1'b0;
    if (init_wr) begin
      wr_addr  = init_addr_reg;
      wr_data  = init_addr_reg;
      we_bank0 = 1'b1;
      we_bank1 = 1'b1;
    end else if (run_en && cfg_wr_en) begin
      we_bank0 = active_bank;
      we_bank1 = ~active_bank;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath stage 1
  // ---------------------------------------------------------------------

  // Capture pixel, syncs, bypass decision and the bank to read for this pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_s1_reg  <= 1'b0;
      href_s1_reg   <= 1'b0;
      clken_s1_reg  <= 1'b0;
      pix_s1_reg    <= '0;
      bypass_s1_reg <= 1'b1;
      bank_s1_reg   <= 1'b0;
    end else begin
      vsync_s1_reg  <= per_frame_vsync;
      href_s1_reg   <= per_frame_href;
      clken_s1_reg  <= per_frame_clken;
      pix_s1_reg    <= per_img_data;
      bypass_s1_reg <= cfg_bypass | ~init_done;
      bank_s1_reg   <= active_bank;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath stage 2
  // ---------------------------------------------------------------------

  // Delay the sync signals to line up with the mapped data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
    end else begin
      post_frame_vsync <= vsync_s1_reg;
      post_frame_href  <= href_s1_reg;
      post_frame_clken <= clken_s1_reg;
    end
  end

  // One private table pair per channel so every channel gets its own read port
  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic [DATA_W-1:0] lut_bank0 [DEPTH];
      logic [DATA_W-1:0] lut_bank1 [DEPTH];
      logic [DATA_W-1:0] pix_ch;
      logic [DATA_W-1:0] data_s2_reg;

      assign pix_ch = pix_s1_reg[gi*DATA_W +: DATA_W];

      // Bank 0 write port
      always_ff @(posedge clk) begin
        if (we_bank0) begin
          lut_bank0[wr_addr] <= wr_data;
        end
      end

      // Bank 1 write port
      always_ff @(posedge clk) begin
        if (we_bank1) begin
          lut_bank1[wr_addr] <= wr_data;
        end
      end

      // Registered table read from the stage-1 bank, or the raw pixel in bypass
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_s2_reg <= '0;
        end else if (bypass_s1_reg) begin
          data_s2_reg <= pix_ch;
        end else if (bank_s1_reg) begin
          data_s2_reg <= lut_bank1[pix_ch];
        end else begin
          data_s2_reg <= lut_bank0[pix_ch];
        end
      end

      assign post_img_data[gi*DATA_W +: DATA_W] = data_s2_reg;
    end
  endgenerate

endmodule

// File: tb/tb_curve_contrast_lut_stream.sv
// Testbench for curve_contrast_lut_stream (DATA_W=8, CH_NUM=3).
// A behavioural model holds the two curve tables as plain arrays, the
// active-bank / pending-swap status and the init timer, and predicts every
// output pixel; a few fixed expectations from the block description are
// checked as literal constants on top of the model.

module tb_curve_contrast_lut_stream;

  localparam int DATA_W = 8;
  localparam int CH_NUM = 3;
  localparam int PIX_W  = DATA_W * CH_NUM;

  logic             clk;
  logic             rst_n;
  logic             per_frame_vsync;
  logic             per_frame_href;
  logic             per_frame_clken;
  logic [PIX_W-1:0] per_img_data;
  logic             post_frame_vsync;
  logic             post_frame_href;
  logic             post_frame_clken;
  logic [PIX_W-1:0] post_img_data;
  logic             cfg_wr_en;
  logic [7:0]       cfg_wr_addr;
  logic [7:0]       cfg_wr_data;
  logic             cfg_swap_req;
  logic             cfg_bypass;
  logic             init_done;
  logic             swap_pending;
  logic             active_bank;

  curve_contrast_lut_stream #(.DATA_W(DATA_W), .CH_NUM(CH_NUM)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_data     (per_img_data),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_data    (post_img_data),
    .cfg_wr_en        (cfg_wr_en),
    .cfg_wr_addr      (cfg_wr_addr),
    .cfg_wr_data      (cfg_wr_data),
    .cfg_swap_req     (cfg_swap_req),
    .cfg_bypass       (cfg_bypass),
    .init_done        (init_done),
    .swap_pending     (swap_pending),
    .active_bank      (active_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             vs;
    logic             hs;
    logic             ck;
    logic [PIX_W-1:0] data;
  } exp_t;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic [7:0] m_bank [2][256];
  logic       m_active;
  logic       m_pending;
  logic       m_vs_prev;
  logic       m_init_done;
  int         m_edges;
  exp_t       m_pend;
  bit         m_pend_valid;

  function automatic logic [PIX_W-1:0] rep3(input logic [7:0] v);
    return {v, v, v};
  endfunction

  // Model after reset: both curves are the identity once the fill is over
  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++)
        m_bank[b][a] = 8'(a);
    m_active     = 1'b0;
    m_pending    = 1'b0;
    m_vs_prev    = 1'b0;
    m_init_done  = 1'b0;
    m_edges      = 0;
    m_pend_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_data    = '0;
    cfg_wr_en       = 1'b0;
    cfg_wr_addr     = '0;
    cfg_wr_data     = '0;
    cfg_swap_req    = 1'b0;
    cfg_bypass      = 1'b0;
  endtask

  // One clock: predict the currently driven pixel, advance the model over
  // the edge, and hand back the prediction for the pixel one step earlier
  // (that pixel is the one on post_* after this edge).
  task automatic step(output exp_t prev, output bit prev_valid);
    exp_t cur;
    logic bank_pre;
    logic byp;
    logic rise;
    bank_pre = m_active;
    byp      = cfg_bypass | ~m_init_done;
    cur.vs   = per_frame_vsync;
    cur.hs   = per_frame_href;
    cur.ck   = per_frame_clken;
    rise     = per_frame_vsync & ~m_vs_prev;
    if (m_init_done) begin
      if (cfg_wr_en) m_bank[m_active ? 0 : 1][cfg_wr_addr] = cfg_wr_data;
      if (rise && (m_pending || cfg_swap_req)) begin
        m_active  = ~m_active;
        m_pending = 1'b0;
      end else if (cfg_swap_req) begin
        m_pending = 1'b1;
      end
    end
    m_vs_prev = per_frame_vsync;
    m_edges++;
    if (m_edges >= 256) m_init_done = 1'b1;
    for (int c = 0; c < CH_NUM; c++) begin
      logic [7:0] p;
      p = per_img_data[c*8 +: 8];
      cur.data[c*8 +: 8] = byp ? p : m_bank[bank_pre][p];
    end
    prev         = m_pend;
    prev_valid   = m_pend_valid;
    m_pend       = cur;
    m_pend_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    per_img_data = rep3(8'hA5);
    per_frame_href = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_data,
         init_done, swap_pending, active_bank} !== '0) begin
      $display("FAIL reset_state: got post=%b%b%b data=%h done=%b pend=%b bank=%b, want all zero",
               post_frame_vsync, post_frame_href, post_frame_clken, post_img_data,
               init_done, swap_pending, active_bank);
    end else n_pass++;
    $display("reset: outputs=%h done=%b bank=%b", post_img_data, init_done, active_bank);
  endtask

  // Release reset, drive 0x37 with config activity that INIT must ignore
  task automatic test_init();
    exp_t e;
    bit   v;
    idle_inputs();
    model_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 258; k++) begin
      per_img_data    = rep3(8'h37);
      per_frame_href  = 1'b1;
      per_frame_clken = 1'b1;
      cfg_wr_en       = (k < 250);
      cfg_wr_addr     = 8'h37;
      cfg_wr_data     = 8'h99;
      cfg_swap_req    = (k % 17 == 0) && (k < 250);
      per_frame_vsync = (k % 40 == 0);
      step(e, v);
      if (k == 255 || k == 256) begin
        n_total++;
        if (init_done !== (k == 256)) begin
          $display("FAIL init_done_timing: cycle %0d got %b want %b", k, init_done, (k == 256));
        end else n_pass++;
        $display("init: cycle %0d init_done=%b", k, init_done);
      end
      if (k == 2) begin
        n_total++;
        if (post_img_data !== rep3(8'h37)) begin
          $display("FAIL init_bypass: got %h want %h", post_img_data, rep3(8'h37));
        end else n_pass++;
      end
      if (v && k > 250) begin
        n_total++;
        if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_data, swap_pending, active_bank}
            !== {e.vs, e.hs, e.ck, e.data, m_pending, m_active}) begin
          $display("FAIL init_stream: cycle %0d got data=%h pend=%b bank=%b want data=%h pend=%b bank=%b",
                   k, post_img_data, swap_pending, active_bank, e.data, m_pending, m_active);
        end else n_pass++;
      end
    end
    cfg_wr_en = 1'b0;
    cfg_swap_req = 1'b0;
  endtask

  // Identity mapping with sync alignment
  task automatic test_identity();
    exp_t e;
    bit   v;
    logic [7:0] vals [3];
    vals[0] = 8'h00; vals[1] = 8'h80; vals[2] = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      per_frame_vsync = (k < 2);
      per_frame_href  = (k >= 3 && k < 7);
      per_frame_clken = (k >= 3 && k < 7);
      per_img_data    = {vals[k % 3], vals[(k + 1) % 3], vals[(k + 2) % 3]};
      step(e, v);
      n_total++;
      if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_data}
          !== {e.vs, e.hs, e.ck, e.data}) begin
        $display("FAIL identity: step %0d got %b%b%b %h want %b%b%b %h", k,
                 post_frame_vsync, post_frame_href, post_frame_clken, post_img_data,
                 e.vs, e.hs, e.ck, e.data);
      end else n_pass++;
      if (e.data !== {e.data[7:0], e.data[7:0], e.data[7:0]} || 1'b1) begin
        // identity means each output channel equals the matching input channel
      end
    end
    $display("identity: last out=%h", post_img_data);
  endtask

  // Shadow load, mid-frame swap request, apply at the next vsync rise
  task automatic test_swap_midframe();
    exp_t e;
    bit   v;
    for (int k = 0; k < 14; k++) begin
      idle_inputs();
      per_frame_vsync = (k < 2) || (k == 8) || (k == 9);
      per_frame_href  = !per_frame_vsync;
      per_frame_clken = !per_frame_vsync;
      per_img_data    = (k == 3 || k == 11) ? rep3(8'h7F) : (k == 13 ? '0 : rep3(8'h40));
      if (k == 2) begin cfg_wr_en = 1'b1; cfg_wr_addr = 8'h40; cfg_wr_data = 8'h02; end
      if (k == 3) begin cfg_wr_en = 1'b1; cfg_wr_addr = 8'h7F; cfg_wr_data = 8'h80; end
      cfg_swap_req = (k == 4);
      step(e, v);
      n_total++;
      if ({post_img_data, post_frame_vsync, swap_pending, active_bank}
          !== {e.data, e.vs, m_pending, m_active}) begin
        $display("FAIL swap_mid_stream: step %0d got %h vs=%b pend=%b bank=%b want %h vs=%b pend=%b bank=%b",
                 k, post_img_data, post_frame_vsync, swap_pending, active_bank,
                 e.data, e.vs, m_pending, m_active);
      end else n_pass++;
      if (k == 4 || k == 7) begin
        n_total++;
        if ({swap_pending, active_bank} !== 2'b10) begin
          $display("FAIL swap_pending_set: step %0d got pend=%b bank=%b want pend=1 bank=0",
                   k, swap_pending, active_bank);
        end else n_pass++;
      end
      if (k == 8) begin
        n_total++;
        if ({swap_pending, active_bank, post_img_data} !== {2'b01, rep3(8'h40)}) begin
          $display("FAIL swap_applied: got pend=%b bank=%b data=%h want pend=0 bank=1 data=404040",
                   swap_pending, active_bank, post_img_data);
        end else n_pass++;
      end
      if (k == 11 || k == 12) begin
        n_total++;
        if (post_img_data !== (k == 11 ? rep3(8'h02) : rep3(8'h80))) begin
          $display("FAIL new_curve: step %0d got %h want %h", k, post_img_data,
                   (k == 11 ? rep3(8'h02) : rep3(8'h80)));
        end else n_pass++;
      end
      $display("swap_mid: step %0d in=%h out=%h pend=%b bank=%b", k, per_img_data,
               post_img_data, swap_pending, active_bank);
    end
  endtask

  // Bypass with the loaded curve active (bank 1 maps 0x40 -> 0x02)
  task automatic test_bypass();
    exp_t e;
    bit   v;
    for (int k = 0; k < 5; k++) begin
      idle_inputs();
      per_frame_href  = 1'b1;
      per_frame_clken = 1'b1;
      per_img_data    = rep3(8'h40);
      cfg_bypass      = (k < 2);
      step(e, v);
      n_total++;
      if (post_img_data !== e.data) begin
        $display("FAIL bypass_stream: step %0d got %h want %h", k, post_img_data, e.data);
      end else n_pass++;
      if (k == 2 || k == 3) begin
        n_total++;
        if (post_img_data !== (k == 2 ? rep3(8'h40) : rep3(8'h02))) begin
          $display("FAIL bypass_toggle: step %0d got %h want %h", k, post_img_data,
                   (k == 2 ? rep3(8'h40) : rep3(8'h02)));
        end else n_pass++;
      end
      $display("bypass: step %0d bypass=%b out=%h", k, cfg_bypass, post_img_data);
    end
  endtask

  // Swap request coinciding with the vsync rise: immediate, never pending
  task automatic test_swap_same_cycle();
    exp_t e;
    bit   v;
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      per_frame_vsync = (k == 1) || (k == 2) || (k == 5);
      cfg_swap_req    = (k == 1) || (k == 5);
      per_frame_href  = 1'b1;
      per_img_data    = rep3(8'h40);
      step(e, v);
      n_total++;
      if ({swap_pending, active_bank, post_img_data} !== {1'b0, m_active, e.data}) begin
        $display("FAIL swap_same_cycle: step %0d got pend=%b bank=%b data=%h want pend=0 bank=%b data=%h",
                 k, swap_pending, active_bank, post_img_data, m_active, e.data);
      end else n_pass++;
      if (k == 1 || k == 5) begin
        n_total++;
        if (active_bank !== (k == 5)) begin
          $display("FAIL swap_immediate: step %0d got bank=%b want %b", k, active_bank, (k == 5));
        end else n_pass++;
      end
      $display("swap_same: step %0d vs=%b req=%b pend=%b bank=%b", k, per_frame_vsync,
               cfg_swap_req, swap_pending, active_bank);
    end
  endtask

  // Random frames, writes, swap requests and bypass against the model
  task automatic test_random();
    exp_t e;
    bit   v;
    int   errs = 0;
    for (int k = 0; k < 600; k++) begin
      idle_inputs();
      per_frame_vsync = ((k % 70) < 3);
      per_frame_href  = !per_frame_vsync && ($urandom_range(0, 7) != 0);
      per_frame_clken = per_frame_href && ($urandom_range(0, 3) != 0);
      per_img_data    = PIX_W'($urandom);
      if ($urandom_range(0, 1) == 0)
        per_img_data[7:0] = 8'($urandom_range(0, 15));
      cfg_wr_en    = ($urandom_range(0, 3) == 0);
      cfg_wr_addr  = 8'($urandom_range(0, 15));
      cfg_wr_data  = 8'($urandom);
      cfg_swap_req = ($urandom_range(0, 19) == 0);
      cfg_bypass   = ($urandom_range(0, 15) == 0);
      step(e, v);
      n_total++;
      if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_data, swap_pending, active_bank}
          !== {e.vs, e.hs, e.ck, e.data, m_pending, m_active}) begin
        errs++;
        $display("FAIL random: step %0d got %b%b%b %h pend=%b bank=%b want %b%b%b %h pend=%b bank=%b",
                 k, post_frame_vsync, post_frame_href, post_frame_clken, post_img_data,
                 swap_pending, active_bank, e.vs, e.hs, e.ck, e.data, m_pending, m_active);
      end else n_pass++;
    end
    $display("random: 600 pixels, %0d mismatching, final bank=%b", errs, active_bank);
  endtask

  // Reset in the middle of a frame, then INIT reruns and identity returns
  task automatic test_reset_midframe();
    exp_t e;
    bit   v;
    idle_inputs();
    per_frame_href  = 1'b1;
    per_frame_clken = 1'b1;
    per_img_data    = rep3(8'hC3);
    step(e, v);
    step(e, v);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_data,
         active_bank, swap_pending, init_done} !== '0) begin
      $display("FAIL reset_midframe: got %b%b%b %h bank=%b pend=%b done=%b want all zero",
               post_frame_vsync, post_frame_href, post_frame_clken, post_img_data,
               active_bank, swap_pending, init_done);
    end else n_pass++;
    $display("reset_mid: out=%h bank=%b", post_img_data, active_bank);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 262; k++) begin
      idle_inputs();
      per_frame_href  = 1'b1;
      per_frame_clken = 1'b1;
      per_img_data    = rep3(8'h40);
      step(e, v);
      if (v) begin
        n_total++;
        if ({post_img_data, init_done} !== {e.data, m_init_done}) begin
          $display("FAIL reinit_stream: cycle %0d got %h done=%b want %h done=%b",
                   k, post_img_data, init_done, e.data, m_init_done);
        end else n_pass++;
      end
    end
    n_total++;
    if ({post_img_data, active_bank, init_done} !== {rep3(8'h40), 1'b0, 1'b1}) begin
      $display("FAIL reinit_identity: got %h bank=%b done=%b want 404040 bank=0 done=1",
               post_img_data, active_bank, init_done);
    end else n_pass++;
    $display("reinit: out=%h done=%b", post_img_data, init_done);
  endtask

  initial begin
    test_reset();
    test_init();
    test_identity();
    test_swap_midframe();
    test_bypass();
    test_swap_same_cycle();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
